// File: rtl/mcu_pkg.sv
// mcu_pkg: opcode, alu mode and state encodings plus sign-extension helpers for the mcu control unit
package mcu_pkg;
  localparam logic [3:0] OP_LD  = 4'b0000;
  localparam logic [3:0] OP_ST  = 4'b0001;
  localparam logic [3:0] OP_MI  = 4'b0010;
  localparam logic [3:0] OP_MR  = 4'b0011;
  localparam logic [3:0] OP_SUM = 4'b0100;
  localparam logic [3:0] OP_SB  = 4'b0101;
  localparam logic [3:0] OP_ANR = 4'b0110;
  localparam logic [3:0] OP_CM  = 4'b0111;
  localparam logic [3:0] OP_ORR = 4'b1000;
  localparam logic [3:0] OP_ORI = 4'b1001;
  localparam logic [3:0] OP_XRR = 4'b1010;
  localparam logic [3:0] OP_XRI = 4'b1011;
  localparam logic [3:0] OP_SMI = 4'b1100;
  localparam logic [3:0] OP_SBI = 4'b1101;
  localparam logic [3:0] OP_ANI = 4'b1110;
  localparam logic [3:0] OP_CMI = 4'b1111;
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_PASS = 3'b101;
  localparam logic [2:0] ALU_CMP  = 3'b110;
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  function automatic logic [7:0] sext2(input logic [1:0] v);
    return {{6{v[1]}}, v};
  endfunction
  function automatic logic [7:0] sext4(input logic [3:0] v);
    return {{4{v[3]}}, v};
  endfunction
endpackage

// File: rtl/mcu_decode.sv
// mcu_decode: combinational instruction-register field, select and alu mode decode
module mcu_decode
  import mcu_pkg::*;
(
  input  logic [7:0] ir,
  output logic [2:0] alu_mode,
  output logic       direct_imm,
  output logic [1:0] rs_sel,
  output logic [1:0] rd_sel,
  output logic [7:0] imm_out,
  output logic       is_mem,
  output logic       is_st,
  output logic       is_cmp,
  output logic       reg_src
);
  logic [3:0] op;
  assign op         = ir[7:4];
  assign is_mem     = op == OP_LD || op == OP_ST;
  assign is_st      = op == OP_ST;
  assign is_cmp     = op == OP_CM || op == OP_CMI;
  assign direct_imm = op inside {OP_MI, OP_ORI, OP_XRI, OP_SMI, OP_SBI, OP_ANI, OP_CMI};
  assign reg_src    = !is_mem && !direct_imm;
  assign rd_sel     = is_mem ? 2'b00 : ir[3:2];
  assign rs_sel     = is_mem ? 2'b00 : ir[1:0];
  assign imm_out    = is_mem ? sext4(ir[3:0]) : direct_imm ? sext2(ir[1:0]) : 8'h00;
  always_comb begin
    alu_mode = ALU_ADD;
    case (op)
      OP_SB,  OP_SBI: alu_mode = ALU_SUB;
      OP_ANR, OP_ANI: alu_mode = ALU_AND;
      OP_ORR, OP_ORI: alu_mode = ALU_OR;
      OP_XRR, OP_XRI: alu_mode = ALU_XOR;
      OP_MR,  OP_MI:  alu_mode = ALU_PASS;
      OP_CM,  OP_CMI: alu_mode = ALU_CMP;
      default:        alu_mode = ALU_ADD;
    endcase
  end
endmodule

// File: rtl/mcu_sequencer.sv
// mcu_sequencer: multi-cycle fetch/decode/exec/mem/wb control unit for the 8-bit processor
module mcu_sequencer
  import mcu_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] PC_RESET = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  input  logic            instr_valid,
  input  logic [7:0]      instr,
  input  logic            mem_ready,
  output logic            instr_req,
  output logic [PC_W-1:0] pc,
  output logic            alu_enable,
  output logic [2:0]      alu_mode,
  output logic            direct_imm,
  output logic [1:0]      rs_sel,
  output logic [1:0]      rd_sel,
  output logic            reg_enable,
  output logic            reg_rw,
  output logic            mem_enable,
  output logic            mem_rw,
  output logic [7:0]      imm_out,
  output logic            busy
);
  logic [2:0] state, state_nx;
  logic [7:0] ir;
  logic [2:0] d_mode;
  logic [1:0] d_rs, d_rd;
  logic [7:0] d_imm;
  logic       d_dimm, d_mem, d_st, d_cmp, d_rsrc, fetch_ok;
  mcu_decode u_dec (
    .ir(ir), .alu_mode(d_mode), .direct_imm(d_dimm), .rs_sel(d_rs), .rd_sel(d_rd),
    .imm_out(d_imm), .is_mem(d_mem), .is_st(d_st), .is_cmp(d_cmp), .reg_src(d_rsrc)
  );
  assign fetch_ok   = state == S_FETCH && instr_valid && run;
  assign instr_req  = state == S_FETCH;
  assign busy       = state != S_IDLE;
  assign alu_enable = state == S_EXEC;
  assign mem_enable = state == S_MEM;
  assign mem_rw     = state == S_MEM && d_st;
  assign reg_rw     = state == S_WB;
  assign reg_enable = state == S_WB || (state == S_EXEC && d_rsrc) || (state == S_MEM && d_st);
  always_comb begin
    state_nx = S_IDLE;
    case (state)
      S_IDLE:   state_nx = run ? S_FETCH : S_IDLE;
      S_FETCH:  state_nx = fetch_ok ? S_DECODE : run ? S_FETCH : S_IDLE;
      S_DECODE: state_nx = d_mem ? S_MEM : S_EXEC;
      S_EXEC:   state_nx = d_cmp ? S_FETCH : S_WB;
      S_MEM:    state_nx = !mem_ready ? S_MEM : d_st ? S_FETCH : S_WB;
      S_WB:     state_nx = S_FETCH;
      default:  state_nx = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pc         <= PC_RESET;
      ir         <= '0;
      alu_mode   <= '0;
      direct_imm <= 1'b0;
      rs_sel     <= '0;
      rd_sel     <= '0;
      imm_out    <= '0;
    end else begin
      state <= state_nx;
      if (fetch_ok) begin
        ir <= instr;
        pc <= pc + 1'b1;
      end
      if (state == S_DECODE) begin
        alu_mode   <= d_mode;
        direct_imm <= d_dimm;
        rs_sel     <= d_rs;
        rd_sel     <= d_rd;
        imm_out    <= d_imm;
      end
    end
  end
endmodule

// File: tb/tb_mcu_sequencer.sv
// tb_mcu_sequencer: directed self-checking bench for mcu_sequencer
module tb_mcu_sequencer;
  logic       clk = 1'b0;
  logic       rst_n, run, instr_valid, mem_ready;
  logic [7:0] instr;
  logic       instr_req, alu_enable, direct_imm, reg_enable, reg_rw, mem_enable, mem_rw, busy;
  logic [7:0] pc, imm_out;
  logic [2:0] alu_mode;
  logic [1:0] rs_sel, rd_sel;
  int         vectors = 0;
  int         miscompares = 0;
  mcu_sequencer dut (
    .clk(clk), .rst_n(rst_n), .run(run), .instr_valid(instr_valid), .instr(instr),
    .mem_ready(mem_ready), .instr_req(instr_req), .pc(pc), .alu_enable(alu_enable),
    .alu_mode(alu_mode), .direct_imm(direct_imm), .rs_sel(rs_sel), .rd_sel(rd_sel),
    .reg_enable(reg_enable), .reg_rw(reg_rw), .mem_enable(mem_enable), .mem_rw(mem_rw),
    .imm_out(imm_out), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  initial begin
    rst_n = 1'b0; run = 1'b0; instr_valid = 1'b0; instr = 8'h00; mem_ready = 1'b0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_pc", pc, 8'h00);
    chk("rst_req", instr_req, 0);
    chk("rst_men", mem_enable, 0);
    chk("rst_ren", reg_enable, 0);
    chk("rst_imm", imm_out, 8'h00);
    rst_n = 1'b1; run = 1'b1; instr_valid = 1'b1; instr = 8'b0100_0110;
    tick();
    chk("sum_fetch_req", instr_req, 1);
    chk("sum_fetch_busy", busy, 1);
    tick();
    instr_valid = 1'b0;
    chk("sum_dec_req", instr_req, 0);
    chk("sum_pc", pc, 8'h01);
    tick();
    chk("sum_ex_aen", alu_enable, 1);
    chk("sum_ex_mode", alu_mode, 3'b000);
    chk("sum_ex_rd", rd_sel, 2'b01);
    chk("sum_ex_rs", rs_sel, 2'b10);
    chk("sum_ex_dimm", direct_imm, 0);
    chk("sum_ex_ren", reg_enable, 1);
    chk("sum_ex_rw", reg_rw, 0);
    tick();
    chk("sum_wb_ren", reg_enable, 1);
    chk("sum_wb_rw", reg_rw, 1);
    chk("sum_wb_aen", alu_enable, 0);
    tick();
    chk("sum_next_fetch", instr_req, 1);
    instr_valid = 1'b1; instr = 8'b1100_0110;
    tick();
    instr_valid = 1'b0;
    tick();
    chk("smi_imm", imm_out, 8'hFE);
    chk("smi_dimm", direct_imm, 1);
    chk("smi_mode", alu_mode, 3'b000);
    chk("smi_rd", rd_sel, 2'b01);
    chk("smi_ren", reg_enable, 0);
    tick();
    chk("smi_wb", reg_rw, 1);
    tick();
    instr_valid = 1'b1; instr = 8'b0000_1010;
    tick();
    instr_valid = 1'b0;
    chk("ld_pc", pc, 8'h03);
    tick();
    chk("ld_imm", imm_out, 8'hFA);
    chk("ld_rd", rd_sel, 2'b00);
    for (int i = 0; i < 4; i++) begin
      chk("ld_men", mem_enable, 1);
      chk("ld_mrw", mem_rw, 0);
      mem_ready = (i == 3);
      tick();
    end
    mem_ready = 1'b0;
    chk("ld_wb_men", mem_enable, 0);
    chk("ld_wb_ren", reg_enable, 1);
    chk("ld_wb_rw", reg_rw, 1);
    chk("ld_wb_rd", rd_sel, 2'b00);
    tick();
    instr_valid = 1'b1; instr = 8'b1111_0001;
    tick();
    instr_valid = 1'b0;
    tick();
    chk("cmi_aen", alu_enable, 1);
    chk("cmi_mode", alu_mode, 3'b110);
    chk("cmi_imm", imm_out, 8'h01);
    chk("cmi_dimm", direct_imm, 1);
    tick();
    chk("cmi_back_fetch", instr_req, 1);
    chk("cmi_no_wb", reg_enable, 0);
    chk("cmi_pc", pc, 8'h04);
    instr_valid = 1'b1; instr = 8'b0111_0000;
    for (int i = 0; i < 251; i++) begin
      tick(); tick(); tick();
    end
    chk("wrap_pre_req", instr_req, 1);
    chk("wrap_pre_pc", pc, 8'hFF);
    tick();
    chk("wrap_pc", pc, 8'h00);
    tick(); tick();
    instr = 8'b0001_0011;
    tick();
    instr_valid = 1'b0;
    tick();
    chk("st_men", mem_enable, 1);
    chk("st_mrw", mem_rw, 1);
    chk("st_ren", reg_enable, 1);
    chk("st_rw", reg_rw, 0);
    chk("st_imm", imm_out, 8'h03);
    tick();
    chk("st_wait_men", mem_enable, 1);
    rst_n = 1'b0; mem_ready = 1'b1;
    tick();
    chk("st_rst_men", mem_enable, 0);
    chk("st_rst_mrw", mem_rw, 0);
    chk("st_rst_busy", busy, 0);
    chk("st_rst_pc", pc, 8'h00);
    chk("st_rst_ren", reg_enable, 0);
    chk("st_rst_imm", imm_out, 8'h00);
    rst_n = 1'b1; mem_ready = 1'b0; run = 1'b0;
    tick();
    chk("idle_hold", busy, 0);
    run = 1'b1;
    tick();
    chk("idle_to_fetch", instr_req, 1);
    run = 1'b0;
    tick();
    chk("fetch_to_idle", busy, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mcu_sequencer.md
Name: mcu_sequencer

Overview:
- Multi-cycle control unit for the 8-bit processor.
- Fetches each 8-bit instruction over a valid/request handshake and decodes the 4-bit opcode plus register and immediate fields.
- Sequences ALU, register file and data memory through FETCH/DECODE/EXEC/MEM/WB.
- Sits between instruction memory and the datapath; supplies datapath enables, selects and the sign-extended immediate.

Parameters:
- PC_W, 8, program counter width.
- PC_RESET, 0, program counter value after reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- run  in  1  when low, the FSM does not leave IDLE or FETCH; an in-flight instruction always completes.
- instr_valid  in  1  instruction memory presents instr this cycle.
- instr  in  8  instruction word; [7:4] opcode, [3:2] rd, [1:0] rs or immediate.
- mem_ready  in  1  data memory completed the current access.
- instr_req  out  1  fetch request; high while in FETCH.
- pc  out  PC_W  address of the next instruction to fetch.
- alu_enable  out  1  ALU evaluates and updates flags.
- alu_mode  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 PASS, 110 CMP.
- direct_imm  out  1  ALU operand B is imm_out; 0 means register rs.
- rs_sel  out  2  source register.
- rd_sel  out  2  destination register.
- reg_enable  out  1  register file access.
- reg_rw  out  1  1 = write, 0 = read.
- mem_enable  out  1  data memory access active.
- mem_rw  out  1  1 = write (ST), 0 = read (LD).
- imm_out  out  8  sign-extended immediate or memory address.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset, sampled at posedge clk with rst_n = 0:
  - state = IDLE, pc = PC_RESET.
  - All outputs 0; instruction register cleared.
  - Takes effect mid-instruction too: mem_enable and reg_enable drop on the next edge and no writeback occurs.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB.
  - IDLE -> FETCH when run = 1.
  - FETCH: instr_req = 1.
    - On instr_valid = 1 and run = 1: latch instr into IR, pc <= pc + 1 (wraps 8'hFF -> 8'h00), go to DECODE.
    - If run drops with no valid instruction: go to IDLE.
  - DECODE: one cycle. Decode IR fields, then:
    - LD or ST -> MEM.
    - All other opcodes -> EXEC.
    - Undefined opcodes: none exist, all 16 are decoded.
  - EXEC: one cycle, alu_enable = 1.
    - CM/CMI -> FETCH (flags only, no writeback).
    - Otherwise -> WB.
  - MEM: mem_enable = 1 held until mem_ready.
    - On mem_ready: LD -> WB, ST -> FETCH.
    - mem_ready sampled in the first MEM cycle gives a zero-wait access.
  - WB: one cycle, reg_enable = 1 and reg_rw = 1, then -> FETCH.
- Field decode, registered in DECODE and held stable until the next DECODE:
  - rd_sel = IR[3:2], rs_sel = IR[1:0].
  - Immediate ops (MI, SMI, SBI, ANI, ORI, XRI, CMI): imm_out = {6{IR[1]}, IR[1:0]}, direct_imm = 1.
  - LD/ST: imm_out = {4{IR[3]}, IR[3:0]} (address); rd_sel and rs_sel forced to 00, so R0 is the implicit data register.
- Opcode map:
  - LD 0000, ST 0001, MI 0010, MR 0011.
  - SUM 0100, SB 0101, ANR 0110, CM 0111.
  - ORR 1000, ORI 1001, XRR 1010, XRI 1011.
  - SMI 1100, SBI 1101, ANI 1110, CMI 1111.
- alu_mode by opcode:
  - SUM/SMI = ADD; SB/SBI = SUB; ANR/ANI = AND; ORR/ORI = OR; XRR/XRI = XOR.
  - MR/MI = PASS; CM/CMI = CMP.
- mem_rw = 1 only in MEM for ST.
- reg_enable with reg_rw = 0 is asserted in EXEC for register-source ops, and in MEM for ST (reads R0).
- Minimum latency, counting the FETCH cycle with instr_valid already high:
  - ALU op: 4 cycles.
  - CM/CMI: 3 cycles.
  - LD: 4 + memory wait cycles.
  - ST: 3 + memory wait cycles.
- No timeout: MEM waits indefinitely for mem_ready.

Decomposition:
- Package mcu_pkg holds:
  - Opcode constants.
  - alu_mode constants.
  - State enum.
  - Helper function for sign extension.
- One sub-module, mcu_decode: combinational IR -> field, select and mode decode.
- The FSM and pc live in mcu_sequencer.

Test Plan:
- Reset then run = 1, instr = 8'b0100_0110 (SUM R1,R2) valid at once -> DECODE, EXEC (alu_mode 000, rd 01, rs 10, direct_imm 0), WB (reg_enable = 1, reg_rw = 1); pc = 1; next FETCH on cycle 5.
- SMI 8'b1100_0110 -> imm_out = 8'hFE, direct_imm = 1, alu_mode 000, rd_sel 01.
- LD 8'b0000_1010 with mem_ready delayed 3 cycles -> imm_out = 8'hFA; mem_enable high for 4 cycles with mem_rw = 0; then WB to R0.
- CMI 8'b1111_0001 -> EXEC with alu_mode 110, imm_out = 8'h01; no WB; returns to FETCH.
- pc = 8'hFF, fetch any instruction -> pc = 8'h00.
- rst_n low during MEM of ST 8'b0001_0011 -> next edge: state IDLE, mem_enable = 0, pc = 0; no write is completed.
